// File: rtl/aibcr3_bypmux_ctl_if.sv
// aibcr3_bypmux_ctl_if: config-side request and mux-side select/gate bundle for the bypass mux sequencer.
interface aibcr3_bypmux_ctl_if #(parameter int DLY_W = 4);
    logic             ctl_en;
    logic             byp_req;
    logic [DLY_W-1:0] settle_cnt;
    logic             byp;
    logic             gate_en;
    logic             busy;
    logic             done;
    modport master (output ctl_en, byp_req, settle_cnt, input byp, gate_en, busy, done);
    modport slave  (input ctl_en, byp_req, settle_cnt, output byp, gate_en, busy, done);
endinterface

// File: rtl/aibcr3_bypmux_ctl.sv
// aibcr3_bypmux_ctl: gates the bypass mux, settles, flips the select, settles again, then ungates.
// Define AIBCR3_BYPMUX_CTL_SYNC_EN to pass byp_req through a 2-flop synchroniser.
module aibcr3_bypmux_ctl #(
    parameter int DLY_W = 4
) (
    input logic clk,
    input logic rst_n,
    aibcr3_bypmux_ctl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GATE, SWITCH} state_t;
    state_t           state;
    logic [DLY_W-1:0] cnt;
    logic [DLY_W-1:0] shadow;
    logic             req_s;
`ifdef AIBCR3_BYPMUX_CTL_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= '0;
        else        sync <= {sync[0], bus.byp_req};
    assign req_s = sync[1];
`else
    assign req_s = bus.byp_req;
`endif
    assign bus.busy = state != IDLE;
    // settle value is latched at GATE entry so both phases use the same count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            shadow      <= '0;
            bus.byp     <= 1'b0;
            bus.gate_en <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.ctl_en && req_s != bus.byp) begin
                    state       <= GATE;
                    bus.gate_en <= 1'b1;
                    cnt         <= bus.settle_cnt;
                    shadow      <= bus.settle_cnt;
                end
                GATE: if (cnt != '0) cnt <= cnt - 1'b1;
                else begin
                    state   <= SWITCH;
                    bus.byp <= ~bus.byp;
                    cnt     <= shadow;
                end
                SWITCH: if (cnt != '0) cnt <= cnt - 1'b1;
                else begin
                    state       <= IDLE;
                    bus.gate_en <= 1'b0;
                    bus.done    <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aibcr3_bypmux_ctl.sv
// tb_aibcr3_bypmux_ctl: directed and random stimulus against a timeline model of the switch sequence.
module tb_aibcr3_bypmux_ctl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    aibcr3_bypmux_ctl_if #(.DLY_W(4)) bus ();
    aibcr3_bypmux_ctl #(.DLY_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    // model: a sequence is a start edge t0 and a settle S; everything else follows by arithmetic
    int   edge_n;
    bit   active;
    int   t0;
    int   s_val;
    bit   m_byp;
    bit   m_done;
    bit   h1, h2;
    bit   prev_byp;
    bit   prev_ok;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        active = 0; m_byp = 0; m_done = 0; h1 = 0; h2 = 0; prev_ok = 0;
    endtask

    task automatic model_edge(input bit req, input bit en, input int s);
        bit req_s;
        bit was_idle;
        int rel;
`ifdef AIBCR3_BYPMUX_CTL_SYNC_EN
        req_s = h2;
        h2 = h1;
        h1 = req;
`else
        req_s = req;
`endif
        edge_n++;
        was_idle = !active;
        m_done = 0;
        if (!was_idle) begin
            rel = edge_n - t0;
            if (rel == s_val + 1) m_byp = !m_byp;
            if (rel == 2 * (s_val + 1)) begin
                active = 0;
                m_done = 1;
            end
        end else if (en && req_s != m_byp) begin
            active = 1;
            t0 = edge_n;
            s_val = s;
        end
    endtask

    task automatic check_outputs();
        check("byp", bus.byp, m_byp);
        check("gate_en", bus.gate_en, active);
        check("busy", bus.busy, active);
        check("done", bus.done, m_done);
        if (prev_ok && bus.byp != prev_byp) check("byp_change_gated", bus.gate_en, 1'b1);
        prev_byp = bus.byp;
        prev_ok = 1;
    endtask

    task automatic step(input bit req, input bit en, input int s);
        bus.byp_req = req;
        bus.ctl_en = en;
        bus.settle_cnt = 4'(s);
        @(posedge clk);
        model_edge(req, en, s);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n, input bit req, input bit en, input int s);
        for (int i = 0; i < n; i++) step(req, en, s);
    endtask

    // asynchronous reset pulse placed between edges; outputs must clear before any clock
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_byp", bus.byp, 1'b0);
        check("rst_gate_en", bus.gate_en, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        edge_n = 0;
        model_reset();
        bus.byp_req = 1'b0;
        bus.ctl_en = 1'b1;
        bus.settle_cnt = '0;
        #1;
        check("por_byp", bus.byp, 1'b0);
        check("por_gate_en", bus.gate_en, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
        run(10, 0, 1, 0);
        run(10, 1, 1, 2);
        run(6, 0, 1, 0);
        run(36, 1, 1, 15);
        run(2, 0, 1, 3);
        run(30, 1, 1, 7);
        run(5, 0, 0, 3);
        run(6, 0, 1, 3);
        async_reset();
        run(5, 0, 1, 3);
        begin
            bit req;
            bit en;
            int s;
            req = 0;
            en = 1;
            s = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(7) == 0) req = !req;
                if ($urandom_range(15) == 0) en = !en;
                if ($urandom_range(3) == 0) s = ($urandom_range(3) == 0) ? int'($urandom_range(15)) : int'($urandom_range(3));
                if ($urandom_range(199) == 0) async_reset();
                step(req, en, s);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
